arbitro_cliente: RTL

// - Requester-side agent for the 4-channel combinational arbiter (arbitro).
// - Queues per-channel service requests and drives arbitro's req[3:0].
// - Consumes grant/grant_num/available and locks ownership for a fixed burst.
// - Presents a stable, single-owner service window to downstream logic.

---
 rtl/arbitro_pkg.sv | 17 +
 rtl/arbitro.sv | 29 ++
 rtl/arbitro_pend_ctr.sv | 59 +++++
 rtl/arbitro_cliente.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/arbitro_pkg.sv
// Shared types for the arbitro requester-side agent and its 4-channel arbiter.
package arbitro_pkg;

    localparam int N_CH = 4;

    typedef logic [1:0] ch_id_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } cli_state_t;

    function automatic logic [N_CH-1:0] ch_onehot(input ch_id_t id);
        return 4'b0001 << id;
    endfunction

endpackage

// File: rtl/arbitro.sv
// 4-channel combinational fixed-priority arbiter; channel 0 has the highest priority.
module arbitro
    import arbitro_pkg::*;
(
    input  logic [N_CH-1:0] req,
    output logic [N_CH-1:0] grant,
    output logic [1:0]      grant_num,
    output logic            available
);

    // Priority encode the request vector
    always_comb begin
        grant     = 4'b0000;
        grant_num = 2'd0;
        available = 1'b0;
        if (req[0]) begin
            grant = 4'b0001; grant_num = 2'd0; available = 1'b1;
        end else if (req[1]) begin
            grant = 4'b0010; grant_num = 2'd1; available = 1'b1;
        end else if (req[2]) begin
            grant = 4'b0100; grant_num = 2'd2; available = 1'b1;
        end else if (req[3]) begin
            grant = 4'b1000; grant_num = 2'd3; available = 1'b1;
        end else begin
            available = 1'b0;
        end
    end

endmodule

// File: rtl/arbitro_pend_ctr.sv
// Saturating per-channel outstanding-request counter with a registered overflow pulse.
module arbitro_pend_ctr #(
    parameter  int DEPTH = 3,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          nonzero,
    output logic          ovf
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          full_s;

    assign full_s = (cnt_q == CW'(DEPTH));

    // A push that coincides with a completion is a net zero and never overflows
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (inc && dec) begin
            cnt_d = cnt_q;
        end else if (inc) begin
            if (full_s) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (dec) begin
            if (cnt_q != {CW{1'b0}}) begin
                cnt_d = cnt_q - CW'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter and overflow pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CW{1'b0}};
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt     = cnt_q;
    assign nonzero = (cnt_q != {CW{1'b0}});
    assign ovf     = ovf_q;

endmodule

// File: rtl/arbitro_cliente.sv
// Requester-side agent for arbitro: queues per-channel requests, locks a granted channel
// for BURST_LEN cycles. Optional FAIR_MASK_EN masks the previous owner while others wait.
module arbitro_cliente
    import arbitro_pkg::*;
#(
    parameter  int BURST_LEN = 4,
    parameter  int DEPTH     = 3,
    localparam int CW        = $clog2(DEPTH + 1),
    localparam int BW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] push,
    output logic [N_CH-1:0] req,
    input  logic [N_CH-1:0] grant,
    input  logic [1:0]      grant_num,
    input  logic            available,
    output logic            busy,
    output logic [1:0]      owner,
    output logic            done,
    output logic [1:0]      done_id,
    output logic [N_CH-1:0] overflow,
    output logic            err
);

    cli_state_t    state_q, state_d;
    ch_id_t        owner_q, owner_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          done_q, done_d;
    ch_id_t        done_id_q, done_id_d;
    logic          err_q, err_d;
`ifdef FAIR_MASK_EN
    ch_id_t        last_owner_q, last_owner_d;
    logic          last_vld_q, last_vld_d;
`endif

    logic [CW-1:0]   pend_cnt_s [N_CH];
    logic [N_CH-1:0] pend_nz_s;
    logic [N_CH-1:0] pend_req_s;
    logic [N_CH-1:0] dec_s;
    logic [N_CH-1:0] req_s;
    logic            err_now_s;

    for (genvar i = 0; i < N_CH; i++) begin : g_ctr
        arbitro_pend_ctr #(.DEPTH(DEPTH)) u_ctr (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc     (push[i]),
            .dec     (dec_s[i]),
            .cnt     (pend_cnt_s[i]),
            .nonzero (pend_nz_s[i]),
            .ovf     (overflow[i])
        );
        assign pend_req_s[i] = (pend_cnt_s[i] != {CW{1'b0}});
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 2'd0;
            beat_q       <= {BW{1'b0}};
            done_q       <= 1'b0;
            done_id_q    <= 2'd0;
            err_q        <= 1'b0;
`ifdef FAIR_MASK_EN
            last_owner_q <= 2'd0;
            last_vld_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            beat_q       <= beat_d;
            done_q       <= done_d;
            done_id_q    <= done_id_d;
            err_q        <= err_d;
`ifdef FAIR_MASK_EN
            last_owner_q <= last_owner_d;
            last_vld_q   <= last_vld_d;
`endif
        end
    end

    // Next-state: arbitration in IDLE, burst countdown in BUSY
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        beat_d       = beat_q;
        done_d       = 1'b0;
        done_id_d    = done_id_q;
        err_d        = err_q | err_now_s;
`ifdef FAIR_MASK_EN
        last_owner_d = last_owner_q;
        last_vld_d   = last_vld_q;
`endif
        case (state_q)
            IDLE: begin
                if (available && (req_s != 4'b0000)) begin
                    state_d = BUSY;
                    owner_d = grant_num;
                    beat_d  = BW'(BURST_LEN - 1);
`ifdef FAIR_MASK_EN
                    last_owner_d = grant_num;
                    last_vld_d   = 1'b1;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (beat_q == {BW{1'b0}}) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    done_id_d = owner_q;
                end else begin
                    beat_d = beat_q - BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: request vector, completion decrement and protocol-violation detect
    always_comb begin
        req_s     = 4'b0000;
        dec_s     = 4'b0000;
        err_now_s = 1'b0;
        if (available && (grant != ch_onehot(grant_num))) begin
            err_now_s = 1'b1;
        end else begin
            err_now_s = 1'b0;
        end
        case (state_q)
            IDLE: begin
`ifdef FAIR_MASK_EN
                if (last_vld_q && ((pend_req_s & ~ch_onehot(last_owner_q)) != 4'b0000)) begin
                    req_s = pend_req_s & ~ch_onehot(last_owner_q);
                end else begin
                    req_s = pend_req_s;
                end
`else
                req_s = pend_req_s;
`endif
                if ((req_s != 4'b0000) && !available) begin
                    err_now_s = 1'b1;
                end else begin
                    err_now_s = err_now_s;
                end
            end
            BUSY: begin
                req_s = ch_onehot(owner_q);
                if (beat_q == {BW{1'b0}}) begin
                    dec_s = ch_onehot(owner_q) & pend_nz_s;
                end else begin
                    dec_s = 4'b0000;
                end
                if (!available || (grant_num != owner_q)) begin
                    err_now_s = 1'b1;
                end else begin
                    err_now_s = err_now_s;
                end
            end
            default: begin
                req_s = 4'b0000;
            end
        endcase
    end

    assign req     = req_s;
    assign busy    = (state_q == BUSY);
    assign owner   = owner_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign err     = err_q;

endmodule
